// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-lights timing blocks.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LIGHTS = 2'b01,
    HOLD   = 2'b10
  } start_state_t;

  // Feedback taps as offsets below the register width: x^W + x^(W-1) + 1.
  localparam int unsigned LfsrTapHiOff = 1;
  localparam int unsigned LfsrTapLoOff = 2;

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Control/status bundle between the start controller and its requester / light FSM.
interface f1_start_ctrl_if #(
  parameter int unsigned LFSR_W = 7
);

  logic              trigger;
  logic              en;
  logic              lights_out;
  logic              busy;
  logic [LFSR_W-1:0] delay_ticks;

  modport master (
    output trigger,
    input  en,
    input  lights_out,
    input  busy,
    input  delay_ticks
  );

  modport slave (
    input  trigger,
    output en,
    output lights_out,
    output busy,
    output delay_ticks
  );

endinterface

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR, advances every cycle; never reaches all-zero from a
// non-zero seed.
module f1_lfsr
  import f1_pkg::*;
#(
  parameter int unsigned       Width = 7,
  parameter logic [Width-1:0] Seed  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [Width-1:0] q
);

  localparam int unsigned TapHi = Width - LfsrTapHiOff;
  localparam int unsigned TapLo = Width - LfsrTapLoOff;

  logic [Width-1:0] q_q;
  logic [Width-1:0] q_d;

  always_comb begin
    q_d = {q_q[Width-2:0], q_q[TapHi] ^ q_q[TapLo]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= Seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// Start-lights timing controller: N_STEPS lamp strobes one tick apart, a random hold,
// then a final lamps-out strobe with lights_out.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int unsigned        TICK_DIV  = 48,
  parameter int unsigned        N_STEPS   = 8,
  parameter int unsigned        LFSR_W    = 7,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 7'h01
) (
  input  logic            clk,
  input  logic            rst_n,
  f1_start_ctrl_if.slave  ctl
);

  localparam int unsigned PreW  = $clog2(TICK_DIV);
  localparam int unsigned StepW = $clog2(N_STEPS + 1);

  localparam logic [PreW-1:0]   PreMax   = PreW'(TICK_DIV - 1);
  localparam logic [StepW-1:0]  StepLast = StepW'(N_STEPS - 1);
  localparam logic [LFSR_W-1:0] HoldLast = LFSR_W'(1);

  start_state_t      state_q;
  logic [PreW-1:0]   presc_q;
  logic [StepW-1:0]  step_q;
  logic [LFSR_W-1:0] hold_q;
  logic [LFSR_W-1:0] delay_q;
  logic              trigger_q;
  logic              en_q;
  logic              lights_out_q;
  logic              busy_q;
  logic [LFSR_W-1:0] lfsr;
  logic              tick;

  f1_lfsr #(
    .Width (LFSR_W),
    .Seed  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign tick = (presc_q == PreMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      step_q       <= '0;
      hold_q       <= '0;
      delay_q      <= '0;
      trigger_q    <= 1'b0;
      en_q         <= 1'b0;
      lights_out_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      trigger_q    <= ctl.trigger;
      en_q         <= 1'b0;
      lights_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edge-qualified so a trigger held across a whole run cannot restart it.
          if (ctl.trigger && !trigger_q) begin
            state_q <= LIGHTS;
            presc_q <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        LIGHTS: begin
          if (tick) begin
            presc_q <= '0;
            en_q    <= 1'b1;
            step_q  <= step_q + StepW'(1);
            if (step_q == StepLast) begin
              state_q <= HOLD;
              delay_q <= lfsr;
              hold_q  <= lfsr;
            end
          end else begin
            presc_q <= presc_q + PreW'(1);
          end
        end
        HOLD: begin
          if (tick) begin
            presc_q <= '0;
            hold_q  <= hold_q - LFSR_W'(1);
            if (hold_q == HoldLast) begin
              en_q         <= 1'b1;
              lights_out_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end
          end else begin
            presc_q <= presc_q + PreW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.en          = en_q;
  assign ctl.lights_out  = lights_out_q;
  assign ctl.busy        = busy_q;
  assign ctl.delay_ticks = delay_q;

  // The light FSM relies on every strobe being exactly one cycle wide.
  a_en_single : assert property (@(posedge clk) disable iff (!rst_n) en_q |=> !en_q);
  a_lo_with_en : assert property (@(posedge clk) disable iff (!rst_n) lights_out_q |-> en_q);
  a_busy_falls : assert property (@(posedge clk) disable iff (!rst_n)
                                  $fell(busy_q) |-> lights_out_q);

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Scoreboard bench for f1_start_ctrl with a chained light-FSM model.
module tb_f1_start_ctrl;

  typedef struct {
    int         cyc;
    logic       lo;
    logic       busy;
    logic [7:0] lamps;
    logic       chk_dt;
    logic [6:0] dt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [6:0] lfsr_m;
  logic [7:0] lamps;

  f1_start_ctrl_if #(.LFSR_W(7)) ctl ();

  f1_start_ctrl #(
    .TICK_DIV  (4),
    .N_STEPS   (8),
    .LFSR_W    (7),
    .LFSR_SEED (7'h01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (ctl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 7'h01;
    else        lfsr_m <= lfsr_step(lfsr_m);
  end

  // Chained light FSM: each en lights one more lamp; the en after all eight goes dark.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lamps <= 8'h00;
    else if (ctl.en)  lamps <= (lamps == 8'hFF) ? 8'h00 : {lamps[6:0], 1'b1};
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t it;
    if (rst_n && (ctl.en || ctl.lights_out)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        it = sb.pop_front();
        check("strobe_cycle", cyc, it.cyc);
        check("en", int'(ctl.en), 1);
        check("lights_out", int'(ctl.lights_out), int'(it.lo));
        check("busy", int'(ctl.busy), int'(it.busy));
        check("lamps_before", int'(lamps), int'(it.lamps));
        if (it.chk_dt) begin
          check("delay_ticks", int'(ctl.delay_ticks), int'(it.dt));
          check("delay_nonzero", int'(ctl.delay_ticks != 7'd0), 1);
        end
      end
    end
  end

  // Drives a rising trigger at the next edge E0 and queues all nine expected strobes.
  task automatic start_run(input bit hold, output int e0, output int fin);
    logic [6:0] d;
    @(negedge clk);
    ctl.trigger = 1'b1;
    e0 = cyc + 1;
    d  = lfsr_m;
    for (int i = 0; i < 32; i++) d = lfsr_step(d);
    for (int k = 1; k <= 8; k++) begin
      sb.push_back('{cyc: e0 + 4 * k, lo: 1'b0, busy: 1'b1,
                     lamps: 8'((1 << (k - 1)) - 1), chk_dt: (k == 8), dt: d});
    end
    fin = e0 + 32 + 4 * int'(d);
    sb.push_back('{cyc: fin, lo: 1'b1, busy: 1'b0, lamps: 8'hFF, chk_dt: 1'b1, dt: d});
    @(negedge clk);
    check("busy_on_accept", int'(ctl.busy), 1);
    check("en_on_accept", int'(ctl.en), 0);
    if (!hold) ctl.trigger = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int e0, fin, e0b, finb;
    ctl.trigger = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle with trigger low
    repeat (50) @(negedge clk);
    check("idle_en", int'(ctl.en), 0);
    check("idle_lights_out", int'(ctl.lights_out), 0);
    check("idle_busy", int'(ctl.busy), 0);
    check("idle_delay_ticks", int'(ctl.delay_ticks), 0);

    // 2: single run
    start_run(1'b0, e0, fin);
    wait_drain(700);
    repeat (5) @(negedge clk);

    // 3: second rising edge mid-run, trigger then held high
    start_run(1'b1, e0, fin);
    repeat (7) @(negedge clk);
    ctl.trigger = 1'b0;
    repeat (2) @(negedge clk);
    ctl.trigger = 1'b1;
    wait_drain(700);
    repeat (20) @(negedge clk);
    check("held_trigger_no_restart", int'(ctl.busy), 0);
    ctl.trigger = 1'b0;
    repeat (3) @(negedge clk);

    // 4: reset in the middle of LIGHTS, while a strobe is high
    start_run(1'b0, e0, fin);
    wait_until(e0 + 16);
    #1 rst_n = 1'b0;
    #1;
    check("rst_en", int'(ctl.en), 0);
    check("rst_busy", int'(ctl.busy), 0);
    check("rst_lights_out", int'(ctl.lights_out), 0);
    check("rst_delay_ticks", int'(ctl.delay_ticks), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_busy", int'(ctl.busy), 0);
    start_run(1'b0, e0, fin);
    wait_drain(700);
    repeat (5) @(negedge clk);

    // 5: retrigger in the lights_out cycle
    start_run(1'b0, e0, fin);
    wait_until(fin - 1);
    start_run(1'b0, e0b, finb);
    wait_drain(1400);
    repeat (5) @(negedge clk);

    // 6: three further runs through the light FSM
    for (int r = 0; r < 3; r++) begin
      start_run(1'b0, e0, fin);
      wait_drain(700);
      repeat (3) @(negedge clk);
      check("lamps_dark_after_run", int'(lamps), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
